// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared opcode encodings, FSM state type and control-strobe bundle for the risc_cpu sequencer.
package cpu_ctrl_fsm_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Instruction-cycle states occupy 0..7 so the 3-bit debug port shows the cycle position.
    typedef enum logic [3:0] {
        ST_FETCH_HI = 4'd0,
        ST_INC_HI   = 4'd1,
        ST_FETCH_LO = 4'd2,
        ST_INC_LO   = 4'd3,
        ST_DECODE   = 4'd4,
        ST_EXEC1    = 4'd5,
        ST_EXEC2    = 4'd6,
        ST_EXEC3    = 4'd7,
        ST_IDLE     = 4'd8,
        ST_HALT     = 4'd9
    } state_e;

    typedef struct packed {
        logic fetch;
        logic ir_byte;
        logic load_ir;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic rd;
        logic wr;
        logic datactl_ena;
        logic halt;
    } ctrl_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm.sv
// Instruction-sequencing controller: two byte fetches plus a three-cycle execute per 16-bit instruction.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned OPC_W       = 3,
    parameter int unsigned IDLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             fetch,
    output logic             ir_byte,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_acc,
    output logic             rd,
    output logic             wr,
    output logic             datactl_ena,
    output logic             halt,
    output logic [2:0]       state
);

    localparam int unsigned    CW        = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0]  IDLE_LAST = CW'(IDLE_CYCLES);

    state_e        state_q, state_d;
    logic [2:0]    opcode_q;
    logic          zero_q;
    logic [CW-1:0] idle_cnt;
    ctrl_t         ctrl_d, ctrl_q;
    logic [2:0]    op_eff;
    logic          zero_eff;

    // Outputs are decoded from the next state, so the opcode/zero sample taken on the
    // same edge must be forwarded from the live inputs rather than the not-yet-loaded copies.
    always_comb begin
        op_eff   = (state_q == ST_INC_LO) ? 3'(opcode) : opcode_q;
        zero_eff = (state_q == ST_DECODE) ? zero : zero_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            zero_q   <= '0;
            idle_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INC_LO) opcode_q <= op_eff;
            if (state_q == ST_DECODE) zero_q <= zero;
            if (state_q == ST_IDLE && idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        ctrl_d  = '0;
        case (state_q)
            ST_IDLE:     state_d = (idle_cnt == IDLE_LAST) ? ST_FETCH_HI : ST_IDLE;
            ST_FETCH_HI: state_d = ST_INC_HI;
            ST_INC_HI:   state_d = ST_FETCH_LO;
            ST_FETCH_LO: state_d = ST_INC_LO;
            ST_INC_LO:   state_d = ST_DECODE;
            ST_DECODE:   state_d = (opcode_q == OP_HLT) ? ST_HALT : ST_EXEC1;
            ST_EXEC1:    state_d = ST_EXEC2;
            ST_EXEC2:    state_d = ST_EXEC3;
            ST_EXEC3:    state_d = ST_FETCH_HI;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_FETCH_HI: begin
                ctrl_d.fetch   = 1'b1;
                ctrl_d.rd      = 1'b1;
                ctrl_d.load_ir = 1'b1;
            end
            ST_INC_HI, ST_INC_LO: begin
                ctrl_d.fetch  = 1'b1;
                ctrl_d.inc_pc = 1'b1;
            end
            ST_FETCH_LO: begin
                ctrl_d.fetch   = 1'b1;
                ctrl_d.rd      = 1'b1;
                ctrl_d.load_ir = 1'b1;
                ctrl_d.ir_byte = 1'b1;
            end
            ST_DECODE: ctrl_d.rd = is_alu_op(op_eff);
            ST_EXEC1: begin
                ctrl_d.rd          = is_alu_op(op_eff);
                ctrl_d.load_acc    = is_alu_op(op_eff);
                ctrl_d.datactl_ena = (op_eff == OP_STO);
                ctrl_d.load_pc     = (op_eff == OP_JMP);
                ctrl_d.inc_pc      = (op_eff == OP_SKZ) && zero_eff;
            end
            ST_EXEC2: begin
                ctrl_d.datactl_ena = (op_eff == OP_STO);
                ctrl_d.wr          = (op_eff == OP_STO);
            end
            ST_EXEC3: ctrl_d.inc_pc = (op_eff == OP_SKZ) && zero_eff;
            ST_HALT:  ctrl_d.halt = 1'b1;
            default:  ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctrl_q <= '0;
        else     ctrl_q <= ctrl_d;
    end

    always_comb begin
        fetch       = ctrl_q.fetch;
        ir_byte     = ctrl_q.ir_byte;
        load_ir     = ctrl_q.load_ir;
        inc_pc      = ctrl_q.inc_pc;
        load_pc     = ctrl_q.load_pc;
        load_acc    = ctrl_q.load_acc;
        rd          = ctrl_q.rd;
        wr          = ctrl_q.wr;
        datactl_ena = ctrl_q.datactl_ena;
        halt        = ctrl_q.halt;
        state       = state_q[2:0];
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: stimulus queues per-cycle expected strobes, a negedge monitor checks them.
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b1;
    logic       rst;
    logic [2:0] opcode;
    logic       zero;
    logic fetch, ir_byte, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt;
    logic [2:0] state;

    typedef struct {
        logic [9:0] v;
        string      tag;
    } exp_t;

    exp_t q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #50 clk = ~clk;

    cpu_ctrl_fsm #(.OPC_W(3), .IDLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
        .fetch(fetch), .ir_byte(ir_byte), .load_ir(load_ir), .inc_pc(inc_pc),
        .load_pc(load_pc), .load_acc(load_acc), .rd(rd), .wr(wr),
        .datactl_ena(datactl_ena), .halt(halt), .state(state)
    );

    // Bit order: fetch ir_byte load_ir inc_pc load_pc load_acc rd wr datactl_ena halt
    function automatic logic [9:0] exp_vec(input int unsigned c, input logic [2:0] op, input logic z);
        logic alu;
        alu = (op == 3'd5) || (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        case (c)
            0:       return 10'b1010001000;
            1, 3:    return 10'b1001000000;
            2:       return 10'b1110001000;
            4:       return alu ? 10'b0000001000 : 10'b0000000000;
            5: begin
                if (alu)                   return 10'b0000011000;
                else if (op == 3'd6)       return 10'b0000000010;
                else if (op == 3'd7)       return 10'b0000100000;
                else if (op == 3'd1 && z)  return 10'b0001000000;
                else                       return 10'b0000000000;
            end
            6:       return (op == 3'd6) ? 10'b0000000110 : 10'b0000000000;
            7:       return (op == 3'd1 && z) ? 10'b0001000000 : 10'b0000000000;
            default: return 10'b0000000000;
        endcase
    endfunction

    task automatic push(input logic [9:0] v, input string tag);
        exp_t e;
        e.v   = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    // Runs cycles 0..ncyc-1 of one instruction; tog flips zero and opcode during EXEC1.
    task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                             input logic tog, input int unsigned ncyc);
        for (int unsigned c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #5;
            push(exp_vec(c, op, z), $sformatf("%s_c%0d", name, c));
            if (c == 0) begin
                opcode = op;
                zero   = z;
            end
            if (c == 5 && tog) begin
                zero   = ~z;
                opcode = ~op;
            end
        end
    endtask

    task automatic do_reset(input string name);
        @(posedge clk);
        #5;
        rst = 1'b1;
        push(10'b0, {name, "_assert"});
        @(posedge clk);
        #5;
        push(10'b0, {name, "_held"});
        #50;
        rst = 1'b0;
        @(posedge clk);
        #5;
        push(10'b0, {name, "_idle"});
    endtask

    always @(negedge clk) begin
        logic [9:0] act;
        exp_t e;
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {fetch, ir_byte, load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt};
            vectors++;
            if (act !== e.v) begin
                miscompares++;
                $display("FAIL %s: got %b expected %b", e.tag, act, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
        #5;
        push(10'b0, "reset_a");
        @(posedge clk);
        #5;
        push(10'b0, "reset_b");
        #50;
        rst = 1'b0;
        @(posedge clk);
        #5;
        push(10'b0, "idle");

        run_instr("lda",      3'd5, 1'b0, 1'b0, 8);
        run_instr("add",      3'd2, 1'b1, 1'b0, 8);
        run_instr("and",      3'd3, 1'b0, 1'b0, 8);
        run_instr("xor",      3'd4, 1'b1, 1'b0, 8);
        run_instr("sto",      3'd6, 1'b0, 1'b0, 8);
        run_instr("skz_z1",   3'd1, 1'b1, 1'b0, 8);
        run_instr("skz_z0",   3'd1, 1'b0, 1'b0, 8);
        run_instr("skz_z1t",  3'd1, 1'b1, 1'b1, 8);
        run_instr("skz_z0t",  3'd1, 1'b0, 1'b1, 8);
        run_instr("jmp",      3'd7, 1'b0, 1'b0, 8);
        run_instr("lda_t",    3'd5, 1'b1, 1'b1, 8);
        run_instr("sto_rst",  3'd6, 1'b0, 1'b0, 6);
        do_reset("rst_exec2");
        run_instr("lda2",     3'd5, 1'b0, 1'b0, 8);
        run_instr("hlt",      3'd0, 1'b0, 1'b0, 5);
        for (int unsigned i = 0; i < 20; i++) begin
            @(posedge clk);
            #5;
            push(10'b0000000001, $sformatf("halt_%0d", i));
            opcode = 3'd5;
        end
        do_reset("rst_halt");
        run_instr("lda3",     3'd5, 1'b0, 1'b0, 8);

        for (int unsigned i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
